// File: rtl/secuencia_checker.sv
// secuencia_checker: locks onto the repeating 3,7,6,6,15,14,7,10,12,14 sequence and flags deviations.
// Ports:
//   C                clock, rising edge
//   nReset           asynchronous active-low reset
//   SecuenciaEntrada sample under check
//   Valido           sample is consumed this cycle
//   Posicion         index 0..9 of last consumed sample, 4'hF when not tracking
//   Bloqueado        high while locked
//   Error            one-cycle pulse per mismatch while locked
//   ContadorErrores  saturating count of Error pulses
//   Siguiente, SiguienteValido  predicted next value (only with SECUENCIA_PREDICT_EN)
module secuencia_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_LIMIT  = 2,
  parameter int CNT_W      = 8
) (
  input  logic             C,
  input  logic             nReset,
  input  logic [3:0]       SecuenciaEntrada,
  input  logic             Valido,
  output logic [3:0]       Posicion,
  output logic             Bloqueado,
  output logic             Error,
  output logic [CNT_W-1:0] ContadorErrores
`ifdef SECUENCIA_PREDICT_EN
  ,
  output logic [3:0]       Siguiente,
  output logic             SiguienteValido
`endif
);
  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;
  localparam logic [39:0] SEQ = {4'd14, 4'd12, 4'd10, 4'd7, 4'd14, 4'd15, 4'd6, 4'd6, 4'd7, 4'd3};
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  localparam logic [3:0] LE = 4'(ERR_LIMIT);
  state_t state_q, state_d;
  logic [3:0] pos_q, pos_d, mcnt_q, mcnt_d, miss_q, miss_d, nxt, expv, anc;
  logic err_q, err_d, hit, is_anc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // nxt is always 0..9 so the table slice never leaves the packed constant
  assign nxt    = (pos_q >= 4'd9) ? 4'd0 : pos_q + 4'd1;
  assign expv   = SEQ[{nxt, 2'b00} +: 4];
  assign hit    = SecuenciaEntrada == expv;
  assign is_anc = SecuenciaEntrada inside {4'd3, 4'd15, 4'd10, 4'd12};
  assign anc    = (SecuenciaEntrada == 4'd3)  ? 4'd0 :
                  (SecuenciaEntrada == 4'd15) ? 4'd4 :
                  (SecuenciaEntrada == 4'd10) ? 4'd7 : 4'd8;
  always_ff @(posedge C or negedge nReset)
    if (!nReset) begin
      state_q <= HUNT;
      pos_q   <= 4'hF;
      mcnt_q  <= '0;
      miss_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      mcnt_q  <= mcnt_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    mcnt_d  = mcnt_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (Valido)
      case (state_q)
        LOCKED: begin
          pos_d = nxt;
          if (hit) miss_d = '0;
          else begin
            err_d = 1'b1;
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            if (miss_q + 4'd1 >= LE) begin
              state_d = HUNT;
              pos_d   = 4'hF;
              miss_d  = '0;
            end else miss_d = miss_q + 4'd1;
          end
        end
        default: begin
          // a failed CONFIRM falls through to the HUNT evaluation of the same sample
          if (state_q == CONFIRM && hit) begin
            pos_d  = nxt;
            mcnt_d = mcnt_q + 4'd1;
            if (mcnt_q + 4'd1 >= LC) state_d = LOCKED;
          end else if (is_anc) begin
            pos_d   = anc;
            mcnt_d  = 4'd1;
            state_d = (LC == 4'd1) ? LOCKED : CONFIRM;
          end else begin
            state_d = HUNT;
            pos_d   = 4'hF;
            mcnt_d  = '0;
          end
        end
      endcase
  end
  assign Posicion        = pos_q;
  assign Bloqueado       = state_q == LOCKED;
  assign Error           = err_q;
  assign ContadorErrores = cnt_q;
`ifdef SECUENCIA_PREDICT_EN
  assign Siguiente       = (state_q != HUNT) ? expv : 4'h0;
  assign SiguienteValido = state_q == LOCKED;
`endif
endmodule

// File: tb/tb_secuencia_checker.sv
// tb_secuencia_checker: table-driven scoreboard bench for secuencia_checker.
module tb_secuencia_checker;
  typedef struct {
    logic       v;
    logic [3:0] d;
    logic [3:0] pos;
    logic       lock;
    logic       err;
    logic [7:0] cnt;
  } vec_t;
  logic C = 1'b0, nReset = 1'b0;
  logic [3:0] d1 = '0, d2 = '0;
  logic v1 = 1'b0, v2 = 1'b0;
  logic [3:0] pos1, pos2;
  logic lock1, lock2, err1, err2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  int compared = 0, mismatched = 0, stepn = 0;
  vec_t tab1[$], tab2[$], tab3[$], exp_q[$];
`ifdef SECUENCIA_PREDICT_EN
  logic [3:0] sig1, sig2;
  logic sv1, sv2;
`endif
  always #5 C = ~C;
  secuencia_checker dut (
    .C(C), .nReset(nReset), .SecuenciaEntrada(d1), .Valido(v1),
    .Posicion(pos1), .Bloqueado(lock1), .Error(err1), .ContadorErrores(cnt1)
`ifdef SECUENCIA_PREDICT_EN
    , .Siguiente(sig1), .SiguienteValido(sv1)
`endif
  );
  secuencia_checker #(.LOCK_COUNT(3), .ERR_LIMIT(15), .CNT_W(2)) dut_sat (
    .C(C), .nReset(nReset), .SecuenciaEntrada(d2), .Valido(v2),
    .Posicion(pos2), .Bloqueado(lock2), .Error(err2), .ContadorErrores(cnt2)
`ifdef SECUENCIA_PREDICT_EN
    , .Siguiente(sig2), .SiguienteValido(sv2)
`endif
  );
  function automatic vec_t mk(int v, int d, int pos, int lock, int err, int cnt);
    vec_t r;
    r.v = v[0]; r.d = d[3:0]; r.pos = pos[3:0]; r.lock = lock[0]; r.err = err[0]; r.cnt = cnt[7:0];
    return r;
  endfunction
  task automatic chk(input string n, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s step %0d: got %0d, required %0d", n, stepn, act, req);
    end
  endtask
  task automatic step(input bit sat, input vec_t e);
    vec_t g;
    if (sat) begin v2 = e.v; d2 = e.d; end
    else begin v1 = e.v; d1 = e.d; end
    exp_q.push_back(e);
    @(posedge C);
    #1;
    g = exp_q.pop_front();
    stepn++;
    chk(sat ? "sat_pos"  : "pos",  sat ? int'(pos2)  : int'(pos1),  int'(g.pos));
    chk(sat ? "sat_lock" : "lock", sat ? int'(lock2) : int'(lock1), int'(g.lock));
    chk(sat ? "sat_err"  : "err",  sat ? int'(err2)  : int'(err1),  int'(g.err));
    chk(sat ? "sat_cnt"  : "cnt",  sat ? int'(cnt2)  : int'(cnt1),  int'(g.cnt));
  endtask
  task automatic chk_reset(input string n);
    chk({n, "_pos"}, int'(pos1), 15);
    chk({n, "_lock"}, int'(lock1), 0);
    chk({n, "_err"}, int'(err1), 0);
    chk({n, "_cnt"}, int'(cnt1), 0);
  endtask
  initial begin
    int sq[10];
    sq = '{3, 7, 6, 6, 15, 14, 7, 10, 12, 14};
    tab1.push_back(mk(1, 3, 0, 0, 0, 0));
    tab1.push_back(mk(1, 7, 1, 0, 0, 0));
    tab1.push_back(mk(1, 6, 2, 1, 0, 0));
    tab1.push_back(mk(1, 6, 3, 1, 0, 0));
    tab1.push_back(mk(1, 15, 4, 1, 0, 0));
    tab1.push_back(mk(1, 14, 5, 1, 0, 0));
    tab1.push_back(mk(1, 7, 6, 1, 0, 0));
    tab1.push_back(mk(1, 9, 7, 1, 1, 1));
    tab1.push_back(mk(1, 12, 8, 1, 0, 1));
    tab1.push_back(mk(1, 5, 9, 1, 1, 2));
    tab1.push_back(mk(1, 5, 15, 0, 1, 3));
    tab1.push_back(mk(1, 6, 15, 0, 0, 3));
    tab1.push_back(mk(1, 6, 15, 0, 0, 3));
    tab1.push_back(mk(1, 15, 4, 0, 0, 3));
    tab1.push_back(mk(1, 14, 5, 0, 0, 3));
    tab1.push_back(mk(1, 7, 6, 1, 0, 3));
    tab1.push_back(mk(0, 9, 6, 1, 0, 3));
    tab1.push_back(mk(0, 10, 6, 1, 0, 3));
    tab1.push_back(mk(0, 2, 6, 1, 0, 3));
    tab1.push_back(mk(0, 12, 6, 1, 0, 3));
    tab1.push_back(mk(1, 10, 7, 1, 0, 3));
    tab1.push_back(mk(1, 12, 8, 1, 0, 3));
    tab1.push_back(mk(1, 14, 9, 1, 0, 3));
    tab1.push_back(mk(1, 3, 0, 1, 0, 3));
    tab1.push_back(mk(1, 5, 1, 1, 1, 4));
    tab1.push_back(mk(1, 5, 15, 0, 1, 5));
    tab1.push_back(mk(1, 3, 0, 0, 0, 5));
    tab1.push_back(mk(1, 15, 4, 0, 0, 5));
    tab1.push_back(mk(1, 6, 15, 0, 0, 5));
    tab1.push_back(mk(1, 12, 8, 0, 0, 5));
    tab1.push_back(mk(1, 14, 9, 0, 0, 5));
    tab1.push_back(mk(1, 3, 0, 1, 0, 5));
    for (int i = 0; i < 11; i++) tab2.push_back(mk(1, sq[i % 10], i % 10, (i >= 2) ? 1 : 0, 0, 0));
    tab3.push_back(mk(1, 3, 0, 0, 0, 0));
    tab3.push_back(mk(1, 7, 1, 0, 0, 0));
    tab3.push_back(mk(1, 6, 2, 1, 0, 0));
    tab3.push_back(mk(1, 5, 3, 1, 1, 1));
    tab3.push_back(mk(1, 5, 4, 1, 1, 2));
    tab3.push_back(mk(1, 5, 5, 1, 1, 3));
    tab3.push_back(mk(1, 5, 6, 1, 1, 3));
    tab3.push_back(mk(1, 5, 7, 1, 1, 3));
    #12;
    chk_reset("init");
    nReset = 1'b1;
    foreach (tab1[i]) step(1'b0, tab1[i]);
    #2;
    nReset = 1'b0;
    #1;
    chk_reset("async");
    @(negedge C);
    nReset = 1'b1;
    foreach (tab2[i]) step(1'b0, tab2[i]);
    v1 = 1'b0;
    foreach (tab3[i]) step(1'b1, tab3[i]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
